// File: rtl/seq_barrel_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : seq_barrel_shifter
//  Description : Multi-cycle barrel shifter (SLL/SRL/SRA/ROL), one binary
//                stage per clock, MSB stage first, fixed SHW-cycle latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_barrel_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    localparam int                 c_k_width = (SHW > 1) ? $clog2(SHW) : 1;
    localparam logic [c_k_width-1:0] c_k_init = c_k_width'(SHW - 1);

    localparam logic [1:0] c_op_sll = 2'b00;
    localparam logic [1:0] c_op_srl = 2'b01;
    localparam logic [1:0] c_op_sra = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   w_load;

    logic [WIDTH-1:0]       r_work;
    logic [SHW-1:0]         r_amt;
    logic [1:0]             r_op;
    logic                   r_sign;
    logic [c_k_width-1:0]   r_k;
    logic [WIDTH-1:0]       r_out;

    logic [WIDTH-1:0]       w_stage [SHW];
    logic [WIDTH-1:0]       w_work_next;

    // Each stage is a fixed-distance rewire of the working register; the
    // stage counter just picks which one to apply this cycle.
    generate
        for (genvar gi = 0; gi < SHW; gi++) begin : g_stage
            localparam int c_dist = 1 << gi;
            logic [WIDTH-1:0] w_res;

            always_comb begin
                case (r_op)
                    c_op_sll: w_res = {r_work[WIDTH-1-c_dist:0], {c_dist{1'b0}}};
                    c_op_srl: w_res = {{c_dist{1'b0}}, r_work[WIDTH-1:c_dist]};
                    c_op_sra: w_res = {{c_dist{r_sign}}, r_work[WIDTH-1:c_dist]};
                    default:  w_res = {r_work[WIDTH-1-c_dist:0], r_work[WIDTH-1:WIDTH-c_dist]};
                endcase
            end

            assign w_stage[gi] = w_res;
        end
    endgenerate

    assign w_work_next = r_amt[r_k] ? w_stage[r_k] : r_work;

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                done = (r_state == S_DONE);
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = S_SHIFT;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (r_k == '0) begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_work  <= '0;
            r_amt   <= '0;
            r_op    <= '0;
            r_sign  <= 1'b0;
            r_k     <= c_k_init;
            r_out   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_work <= a;
                r_amt  <= b;
                r_op   <= op;
                r_sign <= a[WIDTH-1];
                r_k    <= c_k_init;
            end else if (r_state == S_SHIFT) begin
                r_work <= w_work_next;
                if (r_k == '0) begin
                    r_out <= w_work_next;
                end else begin
                    r_k <= r_k - 1'b1;
                end
            end
        end
    end

    assign out = r_out;

endmodule
`default_nettype wire

// File: tb/tb_seq_barrel_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_barrel_shifter
//  Description : Scoreboard bench for seq_barrel_shifter (WIDTH=32), directed
//                vectors with hand-computed results and done-cycle targets.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_barrel_shifter;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;
    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRL = 2'b01;
    localparam logic [1:0] SRA = 2'b10;
    localparam logic [1:0] ROL = 2'b11;

    logic             clk;
    logic             reset;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [SHW-1:0]   b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    seq_barrel_shifter #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done: out=%h at cycle %0d, none expected", out, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (out !== e.data || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL result: out=%h cycle=%0d, required out=%h cycle=%0d",
                             out, cyc, e.data, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL timeout: %0d results outstanding", sb.size());
            sb.delete();
        end
    endtask

    // Issue one op, then scramble the inputs to show they are ignored once accepted.
    task automatic do_op(input logic [1:0] o, input logic [WIDTH-1:0] av,
                         input logic [SHW-1:0] bv, input logic [WIDTH-1:0] expv,
                         input bit chk_busy);
        exp_t e;
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; a = ~av; b = ~bv;
        e.data = expv; e.cyc = cyc + SHW;
        sb.push_back(e);
        if (chk_busy) begin
            for (int i = 0; i < SHW; i++) begin
                @(negedge clk);
                check("busy_during_shift", {31'd0, busy}, 32'd1);
            end
            @(negedge clk);
            check("busy_at_done", {31'd0, busy}, 32'd0);
            check("done_at_latency", {31'd0, done}, 32'd1);
        end
        drain();
    endtask

    initial begin
        exp_t e;
        int   n;
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_out",  out, 32'd0);

        do_op(SLL, 32'h0000_00FF, 5'd8,  32'h0000_FF00, 1'b1);
        do_op(SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0);
        do_op(SRL, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0);
        do_op(SRA, 32'h7FFF_FFFF, 5'd4,  32'h07FF_FFFF, 1'b0);
        do_op(ROL, 32'h8000_0001, 5'd1,  32'h0000_0003, 1'b0);
        do_op(ROL, 32'h1234_5678, 5'd16, 32'h5678_1234, 1'b0);
        do_op(SLL, 32'h1234_5678, 5'd5,  32'h468A_CF00, 1'b0);
        do_op(SRA, 32'hF000_0000, 5'd3,  32'hFE00_0000, 1'b0);
        do_op(ROL, 32'hF000_000F, 5'd4,  32'h0000_00FF, 1'b0);
        do_op(SLL, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0);
        do_op(SRL, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0);
        do_op(SRA, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0);
        do_op(ROL, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b1);
        repeat (3) @(negedge clk);
        check("out_hold", out, 32'hDEAD_BEEF);

        // Second start during busy cycle 2 must be dropped.
        @(negedge clk);
        start = 1'b1; op = SRL; a = 32'hF0F0_F0F0; b = 5'd4;
        @(posedge clk); #1;
        start = 1'b0;
        e.data = 32'h0F0F_0F0F; e.cyc = cyc + SHW; sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b1; op = SLL; a = 32'hFFFF_FFFF; b = 5'd0;
        @(posedge clk); #1;
        start = 1'b0;
        drain();
        repeat (8) @(negedge clk);

        // start held high from the DONE cycle: back-to-back, 6 cycles apart.
        @(negedge clk);
        start = 1'b1; op = SLL; a = 32'h1; b = 5'd1;
        @(posedge clk); #1;
        n = cyc;
        b = 5'd31;
        e.data = 32'h0000_0002; e.cyc = n + SHW;     sb.push_back(e);
        e.data = 32'h8000_0000; e.cyc = n + 2*SHW+1; sb.push_back(e);
        repeat (SHW + 1) @(posedge clk);
        #1 start = 1'b0;
        drain();

        // Reset in SHIFT cycle 3 aborts with no done pulse.
        @(negedge clk);
        start = 1'b1; op = SLL; a = 32'h0000_AAAA; b = 5'd3;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_out",  out, 32'd0);
        repeat (8) @(negedge clk);
        do_op(ROL, 32'h8000_0000, 5'd31, 32'h4000_0000, 1'b0);

        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_empty: %0d left, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
